// File: rtl/exec_pkg.sv
// exec_pkg: shared widths, opcode encoding and FSM states for the execute/writeback stage.
package exec_pkg;
   localparam int EXEC_DATA_W    = 8;
   localparam int EXEC_ADDR_W    = 3;
   localparam int EXEC_MUL_STEPS = 8;
   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_XOR  = 3'b100,
      OP_SLTU = 3'b101,
      OP_MUL  = 3'b110,
      OP_NOP  = 3'b111
   } op_e;
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_OPND = 2'd1,
      S_MUL  = 2'd2,
      S_WB   = 2'd3
   } state_e;
endpackage

// File: rtl/mul_shift_add.sv
// mul_shift_add: iterative shift-add multiplier, one partial product per cycle.
// done/product are combinational in the final step so the caller can register the result directly.
module mul_shift_add #(
   parameter int W     = 8,
   parameter int STEPS = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         done,
   output logic [W-1:0] product
);
   localparam int CW = STEPS > 1 ? $clog2(STEPS) : 1;
   logic [W-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, step;
   logic [CW-1:0] cnt_q, cnt_d;
   logic run_q, run_d;
   always_comb begin
      step    = b_q[cnt_q] ? a_q << cnt_q : '0;
      product = acc_q + step;
      done    = run_q && cnt_q == CW'(STEPS - 1);
      a_d     = start ? a : a_q;
      b_d     = start ? b : b_q;
      acc_d   = start ? '0 : run_q ? product : acc_q;
      cnt_d   = start ? '0 : run_q ? cnt_q + 1'b1 : cnt_q;
      run_d   = start | (run_q & ~done);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end
endmodule

// File: rtl/exec_writeback_stage.sv
// exec_writeback_stage: execute/writeback stage writing results back into the 8x3 register file.
// Define EXEC_MUL_EN to build in MUL; without it op 110 only pulses ILLEGAL_OP.
module exec_writeback_stage
   import exec_pkg::*;
#(
   parameter int DATA_W    = EXEC_DATA_W,
   parameter int ADDR_W    = EXEC_ADDR_W,
   parameter int MUL_STEPS = EXEC_MUL_STEPS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ISSUE_VALID,
   input  logic [2:0]        ISSUE_OP,
   input  logic [ADDR_W-1:0] ISSUE_DEST,
   input  logic [DATA_W-1:0] R1_DATA,
   input  logic [DATA_W-1:0] R2_DATA,
   output logic [ADDR_W-1:0] W_ADDR,
   output logic [DATA_W-1:0] W_DATA,
   output logic              W_ENABLE,
   output logic              BUSY,
   output logic              ZERO,
   output logic              CARRY,
   output logic              ILLEGAL_OP
);
   state_e state_q, state_d;
   logic [2:0] op_q, op_d;
   logic [ADDR_W-1:0] dest_q, dest_d, w_addr_q, w_addr_d;
   logic [DATA_W-1:0] w_data_q, w_data_d, alu_res;
   logic [DATA_W:0] sum, diff;
   logic w_en_q, w_en_d, zero_q, zero_d, carry_q, carry_d, illegal_q, illegal_d;
`ifdef EXEC_MUL_EN
   logic mul_start, mul_done;
   logic [DATA_W-1:0] mul_prod;
   mul_shift_add #(.W(DATA_W), .STEPS(MUL_STEPS)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (R1_DATA),
      .b       (R2_DATA),
      .done    (mul_done),
      .product (mul_prod)
   );
`endif
   always_comb begin
      sum       = {1'b0, R1_DATA} + {1'b0, R2_DATA};
      diff      = {1'b0, R1_DATA} - {1'b0, R2_DATA};
      alu_res   = op_q == OP_ADD ? sum[DATA_W-1:0] :
                  op_q == OP_SUB ? diff[DATA_W-1:0] :
                  op_q == OP_AND ? R1_DATA & R2_DATA :
                  op_q == OP_OR  ? R1_DATA | R2_DATA :
                  op_q == OP_XOR ? R1_DATA ^ R2_DATA : DATA_W'(diff[DATA_W]);
      state_d   = state_q;
      op_d      = op_q;
      dest_d    = dest_q;
      w_en_d    = 1'b0;
      w_addr_d  = w_addr_q;
      w_data_d  = w_data_q;
      zero_d    = zero_q;
      carry_d   = carry_q;
      illegal_d = 1'b0;
`ifdef EXEC_MUL_EN
      mul_start = 1'b0;
`endif
      case (state_q)
         S_IDLE: if (ISSUE_VALID) begin
            op_d    = ISSUE_OP;
            dest_d  = ISSUE_DEST;
            state_d = S_OPND;
`ifndef EXEC_MUL_EN
            illegal_d = ISSUE_OP == OP_MUL;
`endif
         end
         S_OPND: if (op_q == OP_NOP) begin
            state_d = S_IDLE;
         end else if (op_q == OP_MUL) begin
`ifdef EXEC_MUL_EN
            mul_start = 1'b1;
            state_d   = S_MUL;
`else
            state_d   = S_IDLE;
`endif
         end else begin
            w_en_d   = 1'b1;
            w_addr_d = dest_q;
            w_data_d = alu_res;
            zero_d   = alu_res == '0;
            carry_d  = op_q == OP_ADD ? sum[DATA_W] : op_q == OP_SUB ? diff[DATA_W] : carry_q;
            state_d  = S_WB;
         end
`ifdef EXEC_MUL_EN
         S_MUL: if (mul_done) begin
            w_en_d   = 1'b1;
            w_addr_d = dest_q;
            w_data_d = mul_prod;
            zero_d   = mul_prod == '0;
            state_d  = S_WB;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         dest_q    <= '0;
         w_en_q    <= 1'b0;
         w_addr_q  <= '0;
         w_data_q  <= '0;
         zero_q    <= 1'b0;
         carry_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         dest_q    <= dest_d;
         w_en_q    <= w_en_d;
         w_addr_q  <= w_addr_d;
         w_data_q  <= w_data_d;
         zero_q    <= zero_d;
         carry_q   <= carry_d;
         illegal_q <= illegal_d;
      end
   end
   assign W_ADDR     = w_addr_q;
   assign W_DATA     = w_data_q;
   assign W_ENABLE   = w_en_q;
   assign BUSY       = state_q != S_IDLE;
   assign ZERO       = zero_q;
   assign CARRY      = carry_q;
   assign ILLEGAL_OP = illegal_q;
endmodule
